// File: rtl/alu_pipe_if.sv
// Handshake bundle between the ALU pipeline and its producer/consumer.
// The master side drives operands and accepts results; the slave side is the ALU.
interface alu_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         opcode;
  logic               in_valid;
  logic               in_ready;
  logic [2*WIDTH-1:0] op;
  logic               zero;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output a, b, opcode, in_valid, out_ready,
    input  in_ready, op, zero, out_valid
  );

  modport slave (
    input  a, b, opcode, in_valid, out_ready,
    output in_ready, op, zero, out_valid
  );
endinterface

// File: rtl/alu_pipe.sv
// Single-slot ALU: one-cycle ops finish at the accepting edge, MUL runs a
// WIDTH-cycle shift-add; the result is held until the consumer takes it.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input logic      clk,
  input logic      rst,
  alu_pipe_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] op_reg;
  logic               zero_reg;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [CW-1:0]      count;
  logic               last;
  logic [2*WIDTH-1:0] res;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   shl;
  logic [WIDTH-1:0]   shr;

  assign last     = (state == BUSY) && (count == CW'(WIDTH - 1));
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.op        = op_reg;
  assign bus.zero      = zero_reg;

  // Single-cycle results; the extra top bit of diff lands as the borrow.
  always_comb begin
    sum  = {1'b0, bus.a} + {1'b0, bus.b};
    diff = {1'b0, bus.a} - {1'b0, bus.b};
    shl  = bus.a << bus.b;
    shr  = bus.a >> bus.b;
    res  = '0;
    case (bus.opcode)
      3'd0:    res = {{(WIDTH-1){1'b0}}, sum};
      3'd1:    res = {{(WIDTH-1){1'b0}}, diff};
      3'd2:    res = {{WIDTH{1'b0}}, bus.a & bus.b};
      3'd3:    res = {{WIDTH{1'b0}}, bus.a | bus.b};
      3'd4:    res = {{WIDTH{1'b0}}, bus.a ^ bus.b};
      3'd5:    res = {{WIDTH{1'b0}}, shl};
      3'd6:    res = {{WIDTH{1'b0}}, shr};
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.in_valid) state_next = (bus.opcode == 3'd7) ? BUSY : DONE;
      BUSY: if (last) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result and multiplier datapath; op/zero only move when a result is produced.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_reg   <= '0;
      zero_reg <= 1'b1;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.opcode == 3'd7) begin
              mcand  <= {{WIDTH{1'b0}}, bus.a};
              mplier <= bus.b;
              acc    <= '0;
              count  <= '0;
            end else begin
              op_reg   <= res;
              zero_reg <= (res == '0);
            end
          end
        end
        BUSY: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (last) begin
            op_reg   <= acc_next;
            zero_reg <= (acc_next == '0);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
